// File: rtl/eth_rx_fcs_check_if.sv
// Receive byte stream, FCS-stripped output stream and per-frame status of the FCS checker.
interface eth_rx_fcs_check_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 11;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_sof;
  logic              rx_eof;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_sof;
  logic              out_eof;
  logic              frame_done;
  logic              frame_ok;
  logic              crc_err;
  logic              len_err;
  logic [LEN_W-1:0]  frame_len;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof,
    input  out_data, out_valid, out_sof, out_eof,
    input  frame_done, frame_ok, crc_err, len_err, frame_len
  );

  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_eof,
    output out_data, out_valid, out_sof, out_eof,
    output frame_done, frame_ok, crc_err, len_err, frame_len
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: CRC-32 residue check, length check and a 4-byte
// delay line that strips the FCS from the forwarded byte stream.
module eth_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic             clk,
  input  logic             rst_n,
  eth_rx_fcs_check_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CRC_W  = 32;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned FILL_W = 3;

  localparam logic [CRC_W-1:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [CRC_W-1:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [LEN_W-1:0] LEN_SAT     = 11'd2047;

  typedef enum logic {IDLE, RECV} state_t;

  state_t                       state;
  logic [CRC_W-1:0]             crc;
  logic [LEN_W-1:0]             count;
  logic [DEPTH-1:0][DATA_W-1:0] dly;
  logic [FILL_W-1:0]            fill;
  logic                         emitted;

  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_sof_q;
  logic              out_eof_q;
  logic              frame_done_q;
  logic              frame_ok_q;
  logic              crc_err_q;
  logic              len_err_q;
  logic [LEN_W-1:0]  frame_len_q;

  logic             accept;
  logic             start;
  logic [CRC_W-1:0] crc_upd;
  logic [LEN_W-1:0] cnt_nxt;
  logic             crc_bad;
  logic             len_bad;

  // MSB-first shift register fed with bit 0 of each byte first (wire order).
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  always_comb begin
    accept  = bus.rx_valid & (bus.rx_sof | (state == RECV));
    start   = bus.rx_valid & bus.rx_sof;
    crc_upd = crc_byte(start ? CRC_INIT : crc, bus.rx_data);
    if (start)                 cnt_nxt = LEN_W'(1);
    else if (count == LEN_SAT) cnt_nxt = count;
    else                       cnt_nxt = count + LEN_W'(1);
    crc_bad = (crc_upd != CRC_RESIDUE);
    len_bad = (32'(cnt_nxt) < MIN_LEN) || (32'(cnt_nxt) > MAX_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      crc          <= CRC_INIT;
      count        <= '0;
      dly          <= '0;
      fill         <= '0;
      emitted      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        crc   <= crc_upd;
        count <= cnt_nxt;
        dly   <= {dly[DEPTH-2:0], bus.rx_data};
        if (bus.rx_sof) begin
          // New frame: buffer restarts; a frame still open is reported as aborted.
          fill    <= FILL_W'(1);
          emitted <= 1'b0;
          state   <= bus.rx_eof ? IDLE : RECV;
          if (state == RECV) begin
            frame_done_q <= 1'b1;
            frame_ok_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b1;
            frame_len_q  <= count;
          end else if (bus.rx_eof) begin
            frame_done_q <= 1'b1;
            frame_ok_q   <= !crc_bad && !len_bad;
            crc_err_q    <= crc_bad;
            len_err_q    <= len_bad;
            frame_len_q  <= cnt_nxt;
          end
        end else begin
          // Only bytes that have four successors are forwarded, so the FCS never leaves.
          if (fill == FILL_W'(DEPTH)) begin
            out_data_q  <= dly[DEPTH-1];
            out_valid_q <= 1'b1;
            out_sof_q   <= !emitted;
            out_eof_q   <= bus.rx_eof;
            emitted     <= 1'b1;
          end else begin
            fill <= fill + FILL_W'(1);
          end
          if (bus.rx_eof) begin
            state        <= IDLE;
            fill         <= '0;
            frame_done_q <= 1'b1;
            frame_ok_q   <= !crc_bad && !len_bad;
            crc_err_q    <= crc_bad;
            len_err_q    <= len_bad;
            frame_len_q  <= cnt_nxt;
          end
        end
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_eof    = out_eof_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.len_err    = len_err_q;
  assign bus.frame_len  = frame_len_q;
endmodule
